calc_sequencer: RTL and testbench

Keypad-driven sequencer for the 4-bit calculator datapath. It consumes the key strobe and key code from the input unit and issues one-cycle load pulses to the arithmetic unit: operand A, operand B, then result. It also drives the add/subtract select, the input-unit clear, and the display mux select (input vs result). Replaces the ad-hoc control path, adding operator override, clear-entry handling and a configurable ALU settle delay.

---
 rtl/calc_pkg.sv | 25 ++
 rtl/calc_settle_timer.sv | 26 ++
 rtl/calc_sequencer.sv | 156 +++++++++++++++
 tb/tb_calc_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer: state encoding,
// default key codes and the digit classifier.
package calc_pkg;

    typedef enum logic [2:0] {
        S_ENTA = 3'd0,
        S_LDA  = 3'd1,
        S_CLRA = 3'd2,
        S_ENTB = 3'd3,
        S_LDB  = 3'd4,
        S_WAIT = 3'd5,
        S_LDR  = 3'd6,
        S_SHOW = 3'd7
    } state_t;

    localparam logic [3:0] KEY_ADD_DEF     = 4'hA;
    localparam logic [3:0] KEY_SUB_DEF     = 4'hB;
    localparam logic [3:0] KEY_EQ_DEF      = 4'hE;
    localparam int         WAIT_CYCLES_DEF = 2;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/calc_settle_timer.sv
// Loadable 4-bit down-counter; done is raised while the count sits at 1 so the
// caller leaves its wait state on the last counted cycle.
module calc_settle_timer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       done_o
);

    logic [3:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 4'd0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != 4'd0)) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign done_o = (count_q == 4'd1);

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven control sequencer for the 4-bit calculator datapath.
// Define CALC_CHAIN_EN to let an operator key in S_SHOW reuse the result as operand A.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter logic [3:0] KEY_ADD     = KEY_ADD_DEF,
    parameter logic [3:0] KEY_SUB     = KEY_SUB_DEF,
    parameter logic [3:0] KEY_EQ      = KEY_EQ_DEF,
    parameter int         WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       trig,
    input  logic [3:0] value,
    input  logic       clearEntry,
    output logic       loadA,
    output logic       loadB,
    output logic       loadR,
    output logic       addSub,
    output logic       clearIU,
    output logic       iuau,
    output logic       chainSel,
    output logic       busy,
    output logic       keyErr,
    output logic [2:0] state
);

    generate
        if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_wait
            $error("calc_sequencer: WAIT_CYCLES must be in 0..15");
        end
    endgenerate

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t state_q, state_d;
    logic   add_sub_q, add_sub_d;
    logic   key_err_q, key_err_d;
    logic   clr_req_q, clr_req_d;
    logic   tmr_done;
    logic   is_op;

    assign is_op = (value == KEY_ADD) || (value == KEY_SUB);

`ifdef CALC_CHAIN_EN
    logic chain_q, chain_d;
`endif

    calc_settle_timer u_timer (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .load_i     (state_q == S_LDB),
        .load_val_i (WAIT_LD),
        .dec_i      (state_q == S_WAIT),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        add_sub_d = add_sub_q;
        key_err_d = 1'b0;
        clr_req_d = 1'b0;
`ifdef CALC_CHAIN_EN
        chain_d   = 1'b0;
`endif
        // clearEntry is checked before trig everywhere, so a simultaneous key is discarded
        case (state_q)
            S_ENTA: begin
                if (clearEntry) begin
                    clr_req_d = 1'b1;
                end else if (trig) begin
                    if (is_op) begin
                        add_sub_d = (value == KEY_SUB);
                        state_d   = S_LDA;
                    end else if (value == KEY_EQ) begin
                        key_err_d = 1'b1;
                    end
                end
            end
            S_LDA:  state_d = S_CLRA;
            S_CLRA: state_d = S_ENTB;
            S_ENTB: begin
                if (clearEntry) begin
                    clr_req_d = 1'b1;
                end else if (trig) begin
                    if (is_op) begin
                        add_sub_d = (value == KEY_SUB);
                    end else if (value == KEY_EQ) begin
                        state_d = S_LDB;
                    end
                end
            end
            S_LDB:  state_d = (WAIT_LD == 4'd0) ? S_LDR : S_WAIT;
            S_WAIT: if (tmr_done) state_d = S_LDR;
            S_LDR:  state_d = S_SHOW;
            S_SHOW: begin
                if (clearEntry) begin
                    clr_req_d = 1'b1;
                    state_d   = S_ENTA;
                end else if (trig) begin
                    if (is_op) begin
`ifdef CALC_CHAIN_EN
                        add_sub_d = (value == KEY_SUB);
                        chain_d   = 1'b1;
                        state_d   = S_LDA;
`else
                        key_err_d = 1'b1;
`endif
                    end else if (is_digit(value)) begin
                        state_d = S_ENTA;
                    end
                end
            end
            default: state_d = S_ENTA;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_ENTA;
            add_sub_q <= 1'b0;
            key_err_q <= 1'b0;
            clr_req_q <= 1'b0;
`ifdef CALC_CHAIN_EN
            chain_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            add_sub_q <= add_sub_d;
            key_err_q <= key_err_d;
            clr_req_q <= clr_req_d;
`ifdef CALC_CHAIN_EN
            chain_q   <= chain_d;
`endif
        end
    end

    assign loadA   = (state_q == S_LDA);
    assign loadB   = (state_q == S_LDB);
    assign loadR   = (state_q == S_LDR);
    assign clearIU = (state_q == S_CLRA) || (state_q == S_LDR) || clr_req_q;
    assign iuau    = (state_q == S_SHOW);
    assign busy    = (state_q == S_LDA) || (state_q == S_CLRA) || (state_q == S_LDB) ||
                     (state_q == S_WAIT) || (state_q == S_LDR);
    assign addSub  = add_sub_q;
    assign keyErr  = key_err_q;
    assign state   = state_q;

`ifdef CALC_CHAIN_EN
    // chain_q is set only on the S_SHOW -> S_LDA edge, so it spans exactly that S_LDA cycle
    assign chainSel = chain_q;
`else
    assign chainSel = 1'b0;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer; a second instance runs with WAIT_CYCLES = 0.
// Expectations for S_SHOW operator keys follow CALC_CHAIN_EN when defined.
module tb_calc_sequencer;

    logic       clock, reset_n, trig, clearEntry;
    logic [3:0] value;
    logic       loadA, loadB, loadR, addSub, clearIU, iuau, chainSel, busy, keyErr;
    logic [2:0] state;
    logic       z_loadA, z_loadB, z_loadR, z_addSub, z_clearIU, z_iuau, z_chainSel, z_busy, z_keyErr;
    logic [2:0] z_state;

    int tests_run = 0;
    int fails     = 0;

    calc_sequencer dut (
        .clock(clock), .reset_n(reset_n), .trig(trig), .value(value), .clearEntry(clearEntry),
        .loadA(loadA), .loadB(loadB), .loadR(loadR), .addSub(addSub), .clearIU(clearIU),
        .iuau(iuau), .chainSel(chainSel), .busy(busy), .keyErr(keyErr), .state(state)
    );

    calc_sequencer #(.WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .trig(trig), .value(value), .clearEntry(clearEntry),
        .loadA(z_loadA), .loadB(z_loadB), .loadR(z_loadR), .addSub(z_addSub), .clearIU(z_clearIU),
        .iuau(z_iuau), .chainSel(z_chainSel), .busy(z_busy), .keyErr(z_keyErr), .state(z_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        trig  = 1'b1;
        value = k;
        tick();
        trig  = 1'b0;
        value = 4'h0;
    endtask

    task automatic run_to_show(input logic [3:0] a, input logic [3:0] op, input logic [3:0] b);
        press(a); press(op); tick(); tick();
        press(b); press(4'hE);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; trig = 1'b0; value = 4'h0; clearEntry = 1'b0;
        tick();
        tests_run++;
        if ({loadA, loadB, loadR, addSub, clearIU, iuau, chainSel, busy, keyErr, state} !== 12'b0) begin
            fails++; $display("FAIL reset_outputs: got %b expected all zero",
                {loadA, loadB, loadR, addSub, clearIU, iuau, chainSel, busy, keyErr, state});
        end
        tests_run++;
        if ({z_loadA, z_loadB, z_loadR, z_addSub, z_clearIU, z_iuau, z_chainSel, z_busy, z_keyErr, z_state} !== 12'b0) begin
            fails++; $display("FAIL reset_outputs_w0: got nonzero outputs state %0d", z_state);
        end
        reset_n = 1'b1;
        tick();
        tests_run++;
        if (state !== 3'd0) begin fails++; $display("FAIL reset_release_state: got %0d expected 0", state); end
        $display("[TB] reset done");
    endtask

    task automatic test_basic_add();
        int  n;
        logic lr_clr;
        press(4'h3);
        tests_run++;
        if (state !== 3'd0) begin fails++; $display("FAIL add_digit_state: got %0d expected 0", state); end
        press(4'hA);
        tests_run++;
        if ({state, loadA, addSub, busy, chainSel} !== {3'd1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL add_lda: got st=%0d loadA=%b addSub=%b busy=%b chainSel=%b expected st=1 1 0 1 0",
                state, loadA, addSub, busy, chainSel);
        end
        tick();
        tests_run++;
        if ({state, clearIU, loadA} !== {3'd2, 1'b1, 1'b0}) begin
            fails++; $display("FAIL add_clra: got st=%0d clearIU=%b loadA=%b expected st=2 1 0", state, clearIU, loadA);
        end
        tick();
        tests_run++;
        if ({state, clearIU} !== {3'd3, 1'b0}) begin
            fails++; $display("FAIL add_entb: got st=%0d clearIU=%b expected st=3 0", state, clearIU);
        end
        press(4'h2);
        press(4'hE);
        tests_run++;
        if ({state, loadB} !== {3'd4, 1'b1}) begin
            fails++; $display("FAIL add_ldb: got st=%0d loadB=%b expected st=4 1", state, loadB);
        end
        n = 0; lr_clr = 1'b0;
        for (int i = 1; i <= 8 && n == 0; i++) begin
            tick();
            if (loadR === 1'b1) begin n = i; lr_clr = clearIU; end
        end
        tests_run++;
        if (n !== 3) begin fails++; $display("FAIL add_ldr_latency: got %0d cycles expected 3", n); end
        tests_run++;
        if (lr_clr !== 1'b1) begin fails++; $display("FAIL add_ldr_clear: got clearIU=%b expected 1", lr_clr); end
        tick();
        tests_run++;
        if ({state, iuau} !== {3'd7, 1'b1}) begin
            fails++; $display("FAIL add_show: got st=%0d iuau=%b expected st=7 1", state, iuau);
        end
        $display("[TB] basic add 3+2 done");
    endtask

    task automatic test_override();
        int la;
        press(4'h5);
        tests_run++;
        if ({state, iuau} !== {3'd0, 1'b0}) begin
            fails++; $display("FAIL show_digit_exit: got st=%0d iuau=%b expected st=0 0", state, iuau);
        end
        la = 0;
        press(4'hA); la += int'(loadA);
        tick();      la += int'(loadA);
        tick();      la += int'(loadA);
        press(4'hB); la += int'(loadA);
        tests_run++;
        if ({state, addSub} !== {3'd3, 1'b1}) begin
            fails++; $display("FAIL ovr_addsub: got st=%0d addSub=%b expected st=3 1", state, addSub);
        end
        press(4'h1); la += int'(loadA);
        press(4'hE); la += int'(loadA);
        tests_run++;
        if ({loadB, addSub} !== {1'b1, 1'b1}) begin
            fails++; $display("FAIL ovr_ldb: got loadB=%b addSub=%b expected 1 1", loadB, addSub);
        end
        repeat (4) begin tick(); la += int'(loadA); end
        tests_run++;
        if (la !== 1) begin fails++; $display("FAIL ovr_loada_count: got %0d expected 1", la); end
        tests_run++;
        if (state !== 3'd7) begin fails++; $display("FAIL ovr_show: got st=%0d expected 7", state); end
        $display("[TB] operator override 5-1 done");
    endtask

    task automatic test_clear_entry();
        press(4'h4);
        press(4'hE);
        tests_run++;
        if ({state, keyErr} !== {3'd0, 1'b1}) begin
            fails++; $display("FAIL enta_eq_keyerr: got st=%0d keyErr=%b expected st=0 1", state, keyErr);
        end
        tick();
        tests_run++;
        if (keyErr !== 1'b0) begin fails++; $display("FAIL keyerr_pulse: got %b expected 0", keyErr); end
        press(4'hC);
        tests_run++;
        if ({state, keyErr} !== {3'd0, 1'b0}) begin
            fails++; $display("FAIL unknown_key: got st=%0d keyErr=%b expected st=0 0", state, keyErr);
        end
        press(4'hA); tick(); tick();
        trig = 1'b1; value = 4'hE; clearEntry = 1'b1;
        tick();
        trig = 1'b0; value = 4'h0; clearEntry = 1'b0;
        tests_run++;
        if ({state, clearIU, loadB} !== {3'd3, 1'b1, 1'b0}) begin
            fails++; $display("FAIL ce_entb: got st=%0d clearIU=%b loadB=%b expected st=3 1 0", state, clearIU, loadB);
        end
        tick();
        tests_run++;
        if ({state, clearIU, loadB} !== {3'd3, 1'b0, 1'b0}) begin
            fails++; $display("FAIL ce_entb_after: got st=%0d clearIU=%b loadB=%b expected st=3 0 0", state, clearIU, loadB);
        end
        press(4'hE);
        repeat (4) tick();
        clearEntry = 1'b1;
        tick();
        clearEntry = 1'b0;
        tests_run++;
        if ({state, clearIU, iuau} !== {3'd0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL ce_show: got st=%0d clearIU=%b iuau=%b expected st=0 1 0", state, clearIU, iuau);
        end
        $display("[TB] clear entry done");
    endtask

    task automatic test_busy_drop();
        press(4'h6); press(4'hA); tick(); tick();
        press(4'h1); press(4'hE);
        tick();
        tests_run++;
        if ({state, busy} !== {3'd5, 1'b1}) begin
            fails++; $display("FAIL busy_wait: got st=%0d busy=%b expected st=5 1", state, busy);
        end
        press(4'hE);
        tests_run++;
        if ({state, keyErr} !== {3'd5, 1'b0}) begin
            fails++; $display("FAIL busy_drop: got st=%0d keyErr=%b expected st=5 0", state, keyErr);
        end
        tick();
        tests_run++;
        if ({state, loadR} !== {3'd6, 1'b1}) begin
            fails++; $display("FAIL busy_ldr: got st=%0d loadR=%b expected st=6 1", state, loadR);
        end
        $display("[TB] busy drop done");
    endtask

    task automatic test_wait0();
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        press(4'h1); press(4'hA); tick(); tick();
        press(4'h2); press(4'hE);
        tests_run++;
        if ({z_state, z_loadB} !== {3'd4, 1'b1}) begin
            fails++; $display("FAIL w0_ldb: got st=%0d loadB=%b expected st=4 1", z_state, z_loadB);
        end
        tick();
        tests_run++;
        if ({z_state, z_loadR, z_clearIU} !== {3'd6, 1'b1, 1'b1}) begin
            fails++; $display("FAIL w0_ldr: got st=%0d loadR=%b clearIU=%b expected st=6 1 1", z_state, z_loadR, z_clearIU);
        end
        tests_run++;
        if ({state, loadR} !== {3'd5, 1'b0}) begin
            fails++; $display("FAIL w2_still_wait: got st=%0d loadR=%b expected st=5 0", state, loadR);
        end
        tick();
        tests_run++;
        if ({z_state, z_iuau} !== {3'd7, 1'b1}) begin
            fails++; $display("FAIL w0_show: got st=%0d iuau=%b expected st=7 1", z_state, z_iuau);
        end
        $display("[TB] wait_cycles=0 done");
    endtask

    task automatic test_reset_mid();
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        press(4'h1); press(4'hB); tick(); tick();
        press(4'h1); press(4'hE);
        tick();
        tests_run++;
        if ({state, addSub} !== {3'd5, 1'b1}) begin
            fails++; $display("FAIL mid_pre: got st=%0d addSub=%b expected st=5 1", state, addSub);
        end
        #3 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({loadA, loadB, loadR, addSub, clearIU, iuau, chainSel, busy, keyErr, state} !== 12'b0) begin
            fails++; $display("FAIL mid_async_reset: got %b expected all zero",
                {loadA, loadB, loadR, addSub, clearIU, iuau, chainSel, busy, keyErr, state});
        end
        #2 reset_n = 1'b1;
        tick();
        tests_run++;
        if (state !== 3'd0) begin fails++; $display("FAIL mid_after: got st=%0d expected 0", state); end
        $display("[TB] reset mid-operation done");
    endtask

    task automatic test_show_keys();
        run_to_show(4'h2, 4'hA, 4'h3);
        tests_run++;
        if (state !== 3'd7) begin fails++; $display("FAIL sk_show: got st=%0d expected 7", state); end
        press(4'hE);
        tests_run++;
        if ({state, keyErr} !== {3'd7, 1'b0}) begin
            fails++; $display("FAIL sk_eq_ignored: got st=%0d keyErr=%b expected st=7 0", state, keyErr);
        end
        press(4'hB);
`ifdef CALC_CHAIN_EN
        tests_run++;
        if ({state, loadA, chainSel, addSub} !== {3'd1, 1'b1, 1'b1, 1'b1}) begin
            fails++; $display("FAIL sk_chain: got st=%0d loadA=%b chainSel=%b addSub=%b expected st=1 1 1 1",
                state, loadA, chainSel, addSub);
        end
        tick();
        tests_run++;
        if ({state, chainSel} !== {3'd2, 1'b0}) begin
            fails++; $display("FAIL sk_chain_clra: got st=%0d chainSel=%b expected st=2 0", state, chainSel);
        end
`else
        tests_run++;
        if ({state, keyErr, loadA} !== {3'd7, 1'b1, 1'b0}) begin
            fails++; $display("FAIL sk_op_rejected: got st=%0d keyErr=%b loadA=%b expected st=7 1 0", state, keyErr, loadA);
        end
        tick();
        tests_run++;
        if ({state, keyErr, chainSel} !== {3'd7, 1'b0, 1'b0}) begin
            fails++; $display("FAIL sk_op_after: got st=%0d keyErr=%b chainSel=%b expected st=7 0 0", state, keyErr, chainSel);
        end
`endif
        $display("[TB] show-state keys done");
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_override();
        test_clear_entry();
        test_busy_drop();
        test_wait0();
        test_reset_mid();
        test_show_keys();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
